// File: rtl/regfile_fwd_sb_pkg.sv
// Shared core definitions for the forwarding register file and scoreboard:
// default widths and the per-port forward-select encoding.
package regfile_fwd_sb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Source chosen for one read port, listed in decreasing priority
  typedef enum logic [1:0] {
    FWD_ZERO = 2'd0,
    FWD_EX   = 2'd1,
    FWD_WB   = 2'd2,
    FWD_RF   = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/regfile_fwd_sb_read_port.sv
// One decode read port: x0 check, EX/WB bypass selection and the hazard term
// that feeds the decode stall.
module rf_read_port
  import regfile_fwd_sb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   ra,
  input  logic [XLEN-1:0] rf_data,
  input  logic            pend_bit,
  input  logic            ex_we,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_val,
  input  logic            ex_val_ok,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_val,
  output logic [XLEN-1:0] rs,
  output logic            hazard
);

  logic     ra_nz_s;
  logic     ex_match_s;
  logic     wb_match_s;
  fwd_sel_e sel_s;

  assign ra_nz_s    = (ra != {AW{1'b0}});
  assign ex_match_s = ex_we && (ex_rd == ra);
  assign wb_match_s = wb_we && (wb_rd == ra);

  // Priority select: x0, ready EX result, WB result, then the array
  always_comb begin
    sel_s = FWD_RF;
    if (!ra_nz_s) begin
      sel_s = FWD_ZERO;
    end else if (ex_match_s && ex_val_ok) begin
      sel_s = FWD_EX;
    end else if (wb_match_s) begin
      sel_s = FWD_WB;
    end else begin
      sel_s = FWD_RF;
    end
  end

  // Data mux driven by the select
  always_comb begin
    rs = {XLEN{1'b0}};
    case (sel_s)
      FWD_ZERO: rs = {XLEN{1'b0}};
      FWD_EX:   rs = ex_val;
      FWD_WB:   rs = wb_val;
      FWD_RF:   rs = rf_data;
      default:  rs = {XLEN{1'b0}};
    endcase
  end

  // A pending load is satisfied by a same-cycle writeback; an EX result not yet ready is not
  assign hazard = ra_nz_s &&
                  ((pend_bit && !wb_match_s) || (ex_match_s && !ex_val_ok));

endmodule

// File: rtl/regfile_fwd_sb.sv
// Register file with EX/WB forwarding and a long-latency scoreboard that
// stalls decode while a source register is still waiting on its result.
module regfile_fwd_sb
  import regfile_fwd_sb_pkg::*;
#(
  parameter int  XLEN  = XLEN_DEF,
  parameter int  NREGS = NREGS_DEF,
  parameter int  NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_valid,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*XLEN-1:0] rs,
  input  logic              ex_we,
  input  logic [AW-1:0]     ex_rd,
  input  logic [XLEN-1:0]   ex_val,
  input  logic              ex_val_ok,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_val,
  input  logic              issue_we,
  input  logic [AW-1:0]     issue_rd,
  input  logic              issue_long,
  input  logic              flush,
  output logic              stall,
  output logic [AW:0]       pend_cnt
);

  localparam int             CW      = AW + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(NREGS - 1);

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [NREGS-1:0] pend_r;
  logic [CW-1:0]    cnt_r;

  logic [NRD-1:0]   hazard_s;
  logic             stall_s;
  logic             set_s;
  logic             inc_s;
  logic             dec_s;
  logic [NREGS-1:0] set_mask_s;
  logic [NREGS-1:0] clr_mask_s;
  logic [NREGS-1:0] pend_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [AW-1:0] ra_s;
    assign ra_s = ra[i*AW +: AW];

    rf_read_port #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_port (
      .ra        (ra_s),
      .rf_data   (regs_r[ra_s]),
      .pend_bit  (pend_r[ra_s]),
      .ex_we     (ex_we),
      .ex_rd     (ex_rd),
      .ex_val    (ex_val),
      .ex_val_ok (ex_val_ok),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_val    (wb_val),
      .rs        (rs[i*XLEN +: XLEN]),
      .hazard    (hazard_s[i])
    );
  end

  assign stall_s = rd_valid && !flush && (|hazard_s);
  assign stall   = stall_s;
  assign pend_cnt = cnt_r;

  // An issue is only accepted when decode is actually advancing
  assign set_s = issue_we && issue_long && (issue_rd != {AW{1'b0}}) && !stall_s && !flush;

  // Counter deltas follow real bit transitions so the count tracks the popcount
  assign inc_s = set_s && !pend_r[issue_rd];
  assign dec_s = wb_we && pend_r[wb_rd] && !(set_s && (issue_rd == wb_rd));

  // Next scoreboard: clear first so a same-register set wins; x0 never pends
  always_comb begin
    set_mask_s = {NREGS{1'b0}};
    clr_mask_s = {NREGS{1'b0}};
    pend_nxt_s = {NREGS{1'b0}};
    if (set_s) begin
      set_mask_s = NREGS'(1) << issue_rd;
    end else begin
      set_mask_s = {NREGS{1'b0}};
    end
    if (wb_we) begin
      clr_mask_s = NREGS'(1) << wb_rd;
    end else begin
      clr_mask_s = {NREGS{1'b0}};
    end
    if (flush) begin
      pend_nxt_s = {NREGS{1'b0}};
    end else begin
      pend_nxt_s = ((pend_r & ~clr_mask_s) | set_mask_s) & ~(NREGS'(1));
    end
  end

  // Next pending count, saturating at both ends
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (flush) begin
      cnt_nxt_s = {CW{1'b0}};
    end else if (inc_s && !dec_s && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + CW'(1);
    end else if (dec_s && !inc_s && (cnt_r != {CW{1'b0}})) begin
      cnt_nxt_s = cnt_r - CW'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Architectural register array; writes to x0 are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= {XLEN{1'b0}};
      end
    end else if (wb_we && (wb_rd != {AW{1'b0}})) begin
      regs_r[wb_rd] <= wb_val;
    end
  end

  // Scoreboard bits and pending count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= {NREGS{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Directed plus light random bench for regfile_fwd_sb, checked every cycle
// against an array/queue-level model of the forwarding and scoreboard rules.
module tb_regfile_fwd_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rd_valid;
  logic [NRD*AW-1:0]  ra;
  logic [NRD*XLEN-1:0] rs;
  logic               ex_we;
  logic [AW-1:0]      ex_rd;
  logic [XLEN-1:0]    ex_val;
  logic               ex_val_ok;
  logic               wb_we;
  logic [AW-1:0]      wb_rd;
  logic [XLEN-1:0]    wb_val;
  logic               issue_we;
  logic [AW-1:0]      issue_rd;
  logic               issue_long;
  logic               flush;
  logic               stall;
  logic [AW:0]        pend_cnt;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] m_rf   [NREGS];
  logic            m_pend [NREGS];

  always #5 clk = ~clk;

  regfile_fwd_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .rd_valid(rd_valid), .ra(ra), .rs(rs),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_val(ex_val), .ex_val_ok(ex_val_ok),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_val(wb_val),
    .issue_we(issue_we), .issue_rd(issue_rd), .issue_long(issue_long),
    .flush(flush), .stall(stall), .pend_cnt(pend_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rs(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (ex_we && ex_rd == a && ex_val_ok) return ex_val;
    if (wb_we && wb_rd == a) return wb_val;
    return m_rf[a];
  endfunction

  function automatic logic exp_stall();
    logic [AW-1:0] a;
    if (!rd_valid || flush) return 1'b0;
    for (int p = 0; p < NRD; p++) begin
      a = ra[p*AW +: AW];
      if (a != 0 && ((m_pend[a] && !(wb_we && wb_rd == a)) ||
                     (ex_we && ex_rd == a && !ex_val_ok)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int popcnt();
    int n = 0;
    for (int r = 0; r < NREGS; r++) if (m_pend[r]) n++;
    return n;
  endfunction

  // Model state: register contents and the set of registers awaiting a result
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_rf[r]   <= '0;
        m_pend[r] <= 1'b0;
      end
    end else begin
      if (wb_we && wb_rd != 0) m_rf[wb_rd] <= wb_val;
      if (flush) begin
        for (int r = 0; r < NREGS; r++) m_pend[r] <= 1'b0;
      end else begin
        if (wb_we) m_pend[wb_rd] <= 1'b0;
        if (issue_we && issue_long && issue_rd != 0 && !exp_stall())
          m_pend[issue_rd] <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    for (int p = 0; p < NRD; p++)
      chk($sformatf("model_rs%0d", p), 64'(rs[p*XLEN +: XLEN]), 64'(exp_rs(ra[p*AW +: AW])));
    chk("model_stall", 64'(stall), 64'(exp_stall()));
    chk("model_pend_cnt", 64'(pend_cnt), 64'(popcnt()));
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_valid = 0; ex_we = 0; ex_rd = 0; ex_val = 0; ex_val_ok = 0;
    wb_we = 0; wb_rd = 0; wb_val = 0; issue_we = 0; issue_rd = 0;
    issue_long = 0; flush = 0;
  endtask

  initial begin
    idle();
    ra = {5'd5, 5'd0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rs0", 64'(rs[31:0]), 64'h0);
    chk("reset_rs1", 64'(rs[63:32]), 64'h0);
    chk("reset_stall", 64'(stall), 64'h0);
    chk("reset_pend_cnt", 64'(pend_cnt), 64'h0);
    nxt();
    rst = 0;

    // WB bypass, then the array holds the value
    wb_we = 1; wb_rd = 5'd5; wb_val = 32'hDEADBEEF;
    @(negedge clk);
    chk("wb_bypass_rs1", 64'(rs[63:32]), 64'hDEADBEEF);
    nxt(); wb_we = 0;
    @(negedge clk);
    chk("array_rs1", 64'(rs[63:32]), 64'hDEADBEEF);

    // EX beats WB; EX result not ready stalls
    nxt();
    ex_we = 1; ex_rd = 5'd7; ex_val = 32'h11; ex_val_ok = 1;
    wb_we = 1; wb_rd = 5'd7; wb_val = 32'h22; ra = {5'd5, 5'd7}; rd_valid = 1;
    @(negedge clk);
    chk("ex_prio_rs0", 64'(rs[31:0]), 64'h11);
    chk("ex_ok_stall", 64'(stall), 64'h0);
    nxt(); ex_val_ok = 0;
    @(negedge clk);
    chk("ex_notok_stall", 64'(stall), 64'h1);
    chk("ex_notok_rs0", 64'(rs[31:0]), 64'h22);
    nxt(); ex_we = 0; wb_we = 0; rd_valid = 0;

    // Load to x9, dependent read stalls until writeback
    issue_we = 1; issue_rd = 5'd9; issue_long = 1;
    nxt(); issue_we = 0; rd_valid = 1; ra = {5'd9, 5'd0};
    @(negedge clk);
    chk("load_stall", 64'(stall), 64'h1);
    chk("load_pend_cnt", 64'(pend_cnt), 64'h1);
    nxt(); wb_we = 1; wb_rd = 5'd9; wb_val = 32'h55;
    @(negedge clk);
    chk("wb_unstall", 64'(stall), 64'h0);
    chk("wb_rs1", 64'(rs[63:32]), 64'h55);
    nxt(); wb_we = 0;
    @(negedge clk);
    chk("wb_pend_cnt", 64'(pend_cnt), 64'h0);

    // Flush beats a same-cycle issue
    nxt(); rd_valid = 0; issue_we = 1; issue_long = 1; issue_rd = 5'd3;
    nxt(); issue_rd = 5'd4;
    nxt(); issue_rd = 5'd6; flush = 1; rd_valid = 1; ra = {5'd3, 5'd4};
    @(negedge clk);
    chk("preflush_pend_cnt", 64'(pend_cnt), 64'h2);
    chk("flush_stall", 64'(stall), 64'h0);
    nxt(); flush = 0; issue_we = 0; ra = {5'd3, 5'd6};
    @(negedge clk);
    chk("postflush_pend_cnt", 64'(pend_cnt), 64'h0);
    chk("postflush_stall", 64'(stall), 64'h0);

    // x0 is never pending and never written
    nxt(); issue_we = 1; issue_rd = 5'd0; wb_we = 1; wb_rd = 5'd0; wb_val = 32'hFFFFFFFF;
    ra = {5'd0, 5'd0};
    @(negedge clk);
    chk("x0_rs0", 64'(rs[31:0]), 64'h0);
    chk("x0_stall", 64'(stall), 64'h0);
    nxt(); issue_we = 0; wb_we = 0;
    @(negedge clk);
    chk("x0_pend_cnt", 64'(pend_cnt), 64'h0);

    // Same-cycle set and clear of x10 leaves it pending; stalled issues are dropped
    nxt(); rd_valid = 0; issue_we = 1; issue_rd = 5'd10;
    wb_we = 1; wb_rd = 5'd10; wb_val = 32'h77;
    nxt(); issue_we = 0; wb_we = 0; rd_valid = 1; ra = {5'd0, 5'd10};
    @(negedge clk);
    chk("setclr_pend_cnt", 64'(pend_cnt), 64'h1);
    chk("setclr_stall", 64'(stall), 64'h1);
    chk("setclr_rs0", 64'(rs[31:0]), 64'h77);
    nxt(); issue_we = 1; issue_rd = 5'd11;
    nxt(); issue_we = 0;
    @(negedge clk);
    chk("stalled_issue_pend_cnt", 64'(pend_cnt), 64'h1);
    nxt(); wb_we = 1; wb_rd = 5'd10; wb_val = 32'h78;
    nxt(); wb_we = 0;
    @(negedge clk);
    chk("release_pend_cnt", 64'(pend_cnt), 64'h0);

    // Random traffic on a small register window, checked by the model
    for (int c = 0; c < 400; c++) begin
      nxt();
      rd_valid   = 1'($urandom);
      ra         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ex_we      = 1'($urandom);
      ex_rd      = 5'($urandom_range(0, 7));
      ex_val     = $urandom;
      ex_val_ok  = 1'($urandom);
      wb_we      = ($urandom_range(0, 3) == 0);
      wb_rd      = 5'($urandom_range(0, 7));
      wb_val     = $urandom;
      issue_we   = 1'($urandom);
      issue_rd   = 5'($urandom_range(0, 7));
      issue_long = 1'($urandom);
      flush      = ($urandom_range(0, 31) == 0);
    end

    // Asynchronous reset mid-traffic clears state at once
    nxt(); idle(); issue_we = 1; issue_long = 1; issue_rd = 5'd2;
    nxt(); idle(); ra = {5'd5, 5'd2};
    #1 rst = 1;
    @(negedge clk);
    chk("rst_pend_cnt", 64'(pend_cnt), 64'h0);
    chk("rst_rs1", 64'(rs[63:32]), 64'h0);
    nxt(); rst = 0;
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_fwd_sb.md
REGFILE_FWD_SB -- requirements
Module: regfile_fwd_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter NREGS, default 32, architectural register count; AW = clog2(NREGS) derived.
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rd_valid  input  1  decode stage holds a valid instruction.
REQ-007 SHALL have port ra  input  NRD*AW  packed read addresses, port i at [i*AW +: AW].
REQ-008 SHALL have port rs  output  NRD*XLEN  packed forwarded read data.
REQ-009 SHALL have ports ex_we/ex_rd/ex_val/ex_val_ok  input  1/AW/XLEN/1  EX-stage write intent, dest, result, result-ready.
REQ-010 SHALL have ports wb_we/wb_rd/wb_val  input  1/AW/XLEN  writeback write port.
REQ-011 SHALL have ports issue_we/issue_rd/issue_long  input  1/AW/1  decode issues a write; long = load/multicycle result.
REQ-012 SHALL have port flush  input  1  pipeline squash.
REQ-013 SHALL have port stall  output  1  decode must hold.
REQ-014 SHALL have port pend_cnt  output  AW+1  number of pending long-latency registers.

Function
REQ-015 SHALL read register array combinationally; read of register 0 SHALL return 0 regardless of any other input.
REQ-016 SHALL select rs per port by priority: x0 -> 0; ex_we & ex_rd==ra_i & ex_val_ok -> ex_val; wb_we & wb_rd==ra_i -> wb_val; else array.
REQ-017 SHALL write wb_val to array[wb_rd] at clk edge when wb_we and wb_rd!=0; writes to 0 discarded.
REQ-018 SHALL hold one pending bit per register; bit 0 constant 0.
REQ-019 SHALL set pending[issue_rd] when issue_we & issue_long & issue_rd!=0 & !stall & !flush.
REQ-020 SHALL clear pending[wb_rd] when wb_we; same-cycle set and clear of one register SHALL leave it set.
REQ-021 SHALL clear all pending bits on flush; flush SHALL take precedence over same-cycle set.
REQ-022 SHALL assert stall combinationally when rd_valid and any port i with ra_i!=0 has (pending[ra_i] & !(wb_we & wb_rd==ra_i)) or (ex_we & ex_rd==ra_i & !ex_val_ok).
REQ-023 SHALL deassert stall while flush is high.
REQ-024 SHALL maintain pend_cnt as registered popcount-equivalent counter: +1 on accepted set of a clear bit, -1 on clear of a set bit, net 0 when both; reset to 0 on flush.
REQ-025 SHALL never let pend_cnt exceed NREGS-1 or go below 0.

Reset
REQ-026 SHALL, on rst high, immediately clear all array entries, all pending bits and pend_cnt to 0; stall SHALL then depend only on ex_* inputs.
REQ-027 SHALL ignore wb/issue/flush while rst high; first update on first rising edge after rst low.

Structure
REQ-028 SHALL take XLEN, NREGS defaults and the forward-select encoding (ZERO, EX, WB, RF) from the shared core package/header.
REQ-029 SHALL instantiate sub-module rf_read_port NRD times, each doing x0 check, forward select and hazard term for one port.

Verification
REQ-030 Reset then read ra0=0,ra1=5 -> rs0=0, rs1=0, stall=0, pend_cnt=0.
REQ-031 wb_we=1 wb_rd=5 wb_val=0xDEADBEEF, same-cycle ra1=5 -> rs1=0xDEADBEEF; next cycle without wb -> rs1=0xDEADBEEF from array.
REQ-032 ex_we=1 ex_rd=7 ex_val=0x11 ex_val_ok=1 and wb_we=1 wb_rd=7 wb_val=0x22, ra0=7 -> rs0=0x11; ex_val_ok=0 -> stall=1.
REQ-033 Issue load to x9 (issue_long=1), next cycle rd_valid ra1=9 -> stall=1, pend_cnt=1; wb_we wb_rd=9 wb_val=0x55 -> stall=0, rs1=0x55, pend_cnt=0 next cycle.
REQ-034 Issue loads to x3,x4, then flush with issue_long to x6 same cycle -> all pending 0, pend_cnt=0, ra=6 no stall.
REQ-035 Issue load to x0, and wb_we to x0 with 0xFFFFFFFF -> pend_cnt=0, ra=0 returns 0, no stall.
